// File: rtl/dac_table_pkg.sv
// rtl/dac_table_pkg.sv - shared types and sizing for the DAC table replay sequencer
package dac_table_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Two slots beyond the read latency let the stream run at one word per
  // cycle while every outstanding read is still guaranteed a landing slot.
  function automatic int replay_depth(input int ram_lat);
    return ram_lat + 2;
  endfunction

endpackage

// File: rtl/dac_table_replay_fifo.sv
// rtl/dac_table_replay_fifo.sv - first-word-fall-through buffer absorbing table RAM latency
module dac_table_replay_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy tracking; simultaneous push and pop keep count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // The issue rule upstream must never let a returning read find the buffer full.
  overflow_check: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/dac_table_replay_ctrl.sv
// rtl/dac_table_replay_ctrl.sv - table address sequencer and AXI-Stream replay toward the DAC
module dac_table_replay_ctrl
  import dac_table_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RAM_LAT = 2,
  parameter int STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_run,
  input  logic [ADDR_W-1:0]  cfg_length,
  input  logic [STALL_W-1:0] cfg_stall_limit,
  input  logic               stall_clr,
  output logic               ram_en,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               busy,
  output logic               block,
  output logic [15:0]        pass_count
);

  localparam int DEPTH = replay_depth(RAM_LAT);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LEN_W = ADDR_W + 1;

  state_t             state_q;
  state_t             state_d;
  logic [LEN_W-1:0]   latched_len;
  logic [ADDR_W-1:0]  addr_q;
  logic [RAM_LAT-1:0] pipe_valid;
  logic [RAM_LAT-1:0] pipe_last;
  logic [CNT_W-1:0]   in_flight;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [DATA_W:0]    fifo_head;
  logic               issue;
  logic               issue_last;
  logic               handshake;
  logic               stall;
  logic [STALL_W-1:0] stall_cnt;

  // Reads issued but not yet landed in the buffer.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RAM_LAT; i++) begin
      in_flight = in_flight + CNT_W'(pipe_valid[i]);
    end
  end

  assign issue      = (state_q == ST_RUN) &&
                      (({1'b0, in_flight} + {1'b0, fifo_count}) < (CNT_W + 1)'(DEPTH));
  assign issue_last = ({1'b0, addr_q} == (latched_len - LEN_W'(1)));
  assign ram_en     = issue;
  assign ram_addr   = addr_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: run until cfg_run drops, then drain reads and buffer before idling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_run)  state_d = ST_RUN;
      ST_RUN:   if (!cfg_run) state_d = ST_DRAIN;
      ST_DRAIN: if (in_flight == '0 && fifo_empty) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Length is captured only on leaving IDLE; the address restarts at 0 every run.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      latched_len <= '0;
      addr_q      <= '0;
    end else if (state_q == ST_IDLE && cfg_run) begin
      latched_len <= (cfg_length == '0) ? (LEN_W'(1) << ADDR_W) : {1'b0, cfg_length};
      addr_q      <= '0;
    end else if (issue) begin
      addr_q <= issue_last ? '0 : addr_q + ADDR_W'(1);
    end
  end

  // Valid/last tags travel alongside each read for the RAM latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
    end else begin
      pipe_valid <= RAM_LAT'({pipe_valid, issue});
      pipe_last  <= RAM_LAT'({pipe_last, issue && issue_last});
    end
  end

  dac_table_replay_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (pipe_valid[RAM_LAT-1]),
    .push_data ({pipe_last[RAM_LAT-1], ram_rdata}),
    .pop       (handshake),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_head[DATA_W];
  assign handshake     = m_axis_tvalid && m_axis_tready;
  assign stall         = m_axis_tvalid && !m_axis_tready;
  assign busy          = (state_q != ST_IDLE);

  // Stall watchdog: block is sticky, stall_clr takes priority over a limit hit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      block     <= 1'b0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
      block     <= 1'b0;
    end else if (handshake) begin
      stall_cnt <= '0;
    end else if (stall && cfg_stall_limit != '0) begin
      if (stall_cnt < cfg_stall_limit) stall_cnt <= stall_cnt + STALL_W'(1);
      if (({1'b0, stall_cnt} + (STALL_W + 1)'(1)) >= {1'b0, cfg_stall_limit}) block <= 1'b1;
    end
  end

  // Completed table passes, counted on the handshake of each last word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      pass_count <= '0;
    else if (handshake && m_axis_tlast) pass_count <= pass_count + 16'd1;
  end

endmodule

// File: tb/tb_dac_table_replay_ctrl.sv
// tb/tb_dac_table_replay_ctrl.sv - directed self-checking bench for the DAC table replay sequencer
`timescale 1ns/1ps
module tb_dac_table_replay_ctrl;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int RAM_LAT = 2;
  localparam int STALL_W = 16;
  localparam int DEPTH   = RAM_LAT + 2;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic               cfg_run = 1'b0;
  logic [ADDR_W-1:0]  cfg_length = '0;
  logic [STALL_W-1:0] cfg_stall_limit = '0;
  logic               stall_clr = 1'b0;
  logic               ram_en;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_rdata;
  logic [DATA_W-1:0]  m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready = 1'b0;
  logic               m_axis_tlast;
  logic               busy;
  logic               block;
  logic [15:0]        pass_count;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int exp_pass = 0;
  int stab_err = 0;
  int occ_err = 0;
  int issued = 0;
  int popped = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;
  logic [ADDR_W-1:0] ram_a1;

  logic [DATA_W-1:0] q_data[$];
  logic              q_last[$];
  int                q_cyc[$];

  dac_table_replay_ctrl #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .RAM_LAT (RAM_LAT), .STALL_W (STALL_W)
  ) dut (
    .clock (clock), .reset_n (reset_n), .cfg_run (cfg_run), .cfg_length (cfg_length),
    .cfg_stall_limit (cfg_stall_limit), .stall_clr (stall_clr), .ram_en (ram_en),
    .ram_addr (ram_addr), .ram_rdata (ram_rdata), .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid), .m_axis_tready (m_axis_tready),
    .m_axis_tlast (m_axis_tlast), .busy (busy), .block (block), .pass_count (pass_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Two-cycle table RAM: word content encodes its address.
  always @(posedge clock) begin
    ram_a1    <= ram_addr;
    ram_rdata <= {24'hC0FFEE, 4'h0, ram_a1};
  end

  // Stream monitor sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      issued = 0;
      popped = 0;
    end else begin
      if (prev_stall && !(m_axis_tvalid === 1'b1 && m_axis_tdata === prev_data && m_axis_tlast === prev_last))
        stab_err++;
      if (ram_en === 1'b1 && (issued - popped) >= DEPTH) occ_err++;
      if (ram_en === 1'b1) issued++;
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        popped++;
        q_data.push_back(m_axis_tdata);
        q_last.push_back(m_axis_tlast);
        q_cyc.push_back(cyc);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  function automatic int seq_errors(input int first, input int last, input int len);
    int e = 0;
    if (last > q_data.size()) return 1;
    for (int i = first; i < last; i++) begin
      int j = (i - first) % len;
      logic [DATA_W-1:0] w = {24'hC0FFEE, 4'h0, 4'(j)};
      if (q_data[i] !== w || q_last[i] !== (j == len - 1)) e++;
    end
    return e;
  endfunction

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    stab_err = 0;
    occ_err = 0;
  endtask

  task automatic start_run(output int c0);
    @(posedge clock);
    #1 cfg_run = 1'b1;
    c0 = cyc;
  endtask

  task automatic stop_run();
    @(posedge clock);
    #1 cfg_run = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clock);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); else passes++;
    checks++; if (m_axis_tdata !== '0) $display("FAIL reset_tdata got %h want 0", m_axis_tdata); else passes++;
    checks++; if (ram_en !== 1'b0 || ram_addr !== '0) $display("FAIL reset_ram got en=%b addr=%h want 0/0", ram_en, ram_addr); else passes++;
    checks++; if (busy !== 1'b0 || block !== 1'b0) $display("FAIL reset_flags got busy=%b block=%b want 0/0", busy, block); else passes++;
    checks++; if (pass_count !== 16'd0) $display("FAIL reset_pass got %0d want 0", pass_count); else passes++;
  endtask

  task automatic test_stream_len4();
    int c0, n;
    cfg_length = 4; cfg_stall_limit = 0; m_axis_tready = 1'b1;
    clear_mon();
    start_run(c0);
    repeat (19) @(posedge clock);
    stop_run();
    wait_idle();
    n = q_data.size();
    checks++; if (busy !== 1'b0) $display("FAIL len4_idle got busy=%b want 0", busy); else passes++;
    checks++; if (n != 20) $display("FAIL len4_count got %0d want 20", n); else passes++;
    checks++; if (seq_errors(0, n, 4) != 0) $display("FAIL len4_seq got %0d bad words want 0", seq_errors(0, n, 4)); else passes++;
    checks++; if ((n > 0 ? q_cyc[0] : -1) != c0 + 4) $display("FAIL len4_latency got cycle %0d want %0d", (n > 0 ? q_cyc[0] : -1), c0 + 4); else passes++;
    checks++; if ((n > 0 ? q_cyc[n-1] - q_cyc[0] : -1) != n - 1) $display("FAIL len4_bubbles got span %0d want %0d", (n > 0 ? q_cyc[n-1] - q_cyc[0] : -1), n - 1); else passes++;
    exp_pass += 5;
    checks++; if (pass_count !== 16'(exp_pass)) $display("FAIL len4_pass got %0d want %0d", pass_count, exp_pass); else passes++;
  endtask

  task automatic test_random_backpressure();
    int c0, n;
    cfg_length = 7; cfg_stall_limit = 0; m_axis_tready = 1'b0;
    clear_mon();
    start_run(c0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      #1 m_axis_tready = ($urandom_range(0, 99) < 30);
    end
    stop_run();
    wait_idle();
    n = q_data.size();
    checks++; if (busy !== 1'b0) $display("FAIL rand_idle got busy=%b want 0", busy); else passes++;
    checks++; if (n < 30) $display("FAIL rand_count got %0d want >=30", n); else passes++;
    checks++; if (seq_errors(0, n, 7) != 0) $display("FAIL rand_seq got %0d bad words want 0", seq_errors(0, n, 7)); else passes++;
    checks++; if (stab_err != 0) $display("FAIL rand_hold got %0d unstable stalls want 0", stab_err); else passes++;
    checks++; if (occ_err != 0) $display("FAIL rand_depth got %0d over-issues want 0", occ_err); else passes++;
    exp_pass += n / 7;
    checks++; if (pass_count !== 16'(exp_pass)) $display("FAIL rand_pass got %0d want %0d", pass_count, exp_pass); else passes++;
  endtask

  task automatic test_drain();
    int c0, n;
    cfg_length = 7; cfg_stall_limit = 0; m_axis_tready = 1'b0;
    clear_mon();
    start_run(c0);
    repeat (10) @(negedge clock);
    checks++; if (ram_en !== 1'b0 || m_axis_tvalid !== 1'b1) $display("FAIL drain_full got en=%b tvalid=%b want 0/1", ram_en, m_axis_tvalid); else passes++;
    checks++; if (m_axis_tdata !== 32'hC0FFEE00) $display("FAIL drain_head got %h want c0ffee00", m_axis_tdata); else passes++;
    @(posedge clock);
    #1 cfg_run = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b1) $display("FAIL drain_busy got %b want 1", busy); else passes++;
    @(posedge clock);
    #1 cfg_run = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (ram_en !== 1'b0) $display("FAIL drain_rerun_ignored got en=%b want 0", ram_en); else passes++;
    checks++; if (block !== 1'b0) $display("FAIL drain_wd_disabled got block=%b want 0", block); else passes++;
    @(posedge clock);
    #1 m_axis_tready = 1'b1;
    repeat (20) @(posedge clock);
    stop_run();
    wait_idle();
    n = q_data.size();
    checks++; if (busy !== 1'b0) $display("FAIL drain_idle got busy=%b want 0", busy); else passes++;
    checks++; if (n <= 4) $display("FAIL drain_restart_count got %0d want >4", n); else passes++;
    checks++; if (seq_errors(0, 4, 7) != 0) $display("FAIL drain_old_words got %0d bad want 0", seq_errors(0, 4, 7)); else passes++;
    checks++; if (seq_errors(4, n, 7) != 0) $display("FAIL drain_restart_seq got %0d bad want 0", seq_errors(4, n, 7)); else passes++;
    exp_pass += (n - 4) / 7;
    checks++; if (pass_count !== 16'(exp_pass)) $display("FAIL drain_pass got %0d want %0d", pass_count, exp_pass); else passes++;
  endtask

  task automatic test_watchdog();
    int c0, n;
    cfg_length = 4; cfg_stall_limit = 10; m_axis_tready = 1'b0;
    clear_mon();
    start_run(c0);
    for (int i = 0; i < 20 && m_axis_tvalid !== 1'b1; i++) @(negedge clock);
    checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL wd_tvalid got %b want 1", m_axis_tvalid); else passes++;
    repeat (9) @(negedge clock);
    checks++; if (block !== 1'b0) $display("FAIL wd_stall9 got block=%b want 0", block); else passes++;
    @(negedge clock);
    checks++; if (block !== 1'b1) $display("FAIL wd_stall10 got block=%b want 1", block); else passes++;
    @(posedge clock);
    #1 m_axis_tready = 1'b1;
    repeat (5) @(negedge clock);
    checks++; if (block !== 1'b1) $display("FAIL wd_sticky got block=%b want 1", block); else passes++;
    @(posedge clock);
    #1 stall_clr = 1'b1;
    @(posedge clock);
    #1 stall_clr = 1'b0;
    @(negedge clock);
    checks++; if (block !== 1'b0) $display("FAIL wd_clear got block=%b want 0", block); else passes++;
    stop_run();
    wait_idle();
    n = q_data.size();
    checks++; if (seq_errors(0, n, 4) != 0 || n == 0) $display("FAIL wd_seq got %0d bad of %0d want 0", seq_errors(0, n, 4), n); else passes++;
    exp_pass += n / 4;
    checks++; if (pass_count !== 16'(exp_pass)) $display("FAIL wd_pass got %0d want %0d", pass_count, exp_pass); else passes++;
  endtask

  task automatic test_length_edges();
    int c0, n;
    cfg_length = 0; cfg_stall_limit = 0; m_axis_tready = 1'b1;
    clear_mon();
    start_run(c0);
    repeat (39) @(posedge clock);
    stop_run();
    wait_idle();
    n = q_data.size();
    checks++; if (n != 40) $display("FAIL len0_count got %0d want 40", n); else passes++;
    checks++; if (seq_errors(0, n, 16) != 0) $display("FAIL len0_seq got %0d bad want 0", seq_errors(0, n, 16)); else passes++;
    checks++; if ((n > 15 ? q_last[15] : 1'b0) !== 1'b1) $display("FAIL len0_last15 got %b want 1", (n > 15 ? q_last[15] : 1'b0)); else passes++;
    exp_pass += 2;
    checks++; if (pass_count !== 16'(exp_pass)) $display("FAIL len0_pass got %0d want %0d", pass_count, exp_pass); else passes++;
    cfg_length = 1;
    clear_mon();
    start_run(c0);
    repeat (5) @(posedge clock);
    #1 cfg_length = 5;
    repeat (6) @(posedge clock);
    stop_run();
    wait_idle();
    n = q_data.size();
    checks++; if (n != 12) $display("FAIL len1_count got %0d want 12", n); else passes++;
    checks++; if (seq_errors(0, n, 1) != 0) $display("FAIL len1_seq got %0d bad want 0", seq_errors(0, n, 1)); else passes++;
    exp_pass += 12;
    checks++; if (pass_count !== 16'(exp_pass)) $display("FAIL len1_pass got %0d want %0d", pass_count, exp_pass); else passes++;
  endtask

  task automatic test_async_reset();
    int c0, n;
    cfg_length = 4; cfg_stall_limit = 3; m_axis_tready = 1'b0;
    clear_mon();
    start_run(c0);
    repeat (10) @(negedge clock);
    checks++; if (block !== 1'b1 || m_axis_tvalid !== 1'b1) $display("FAIL arst_pre got block=%b tvalid=%b want 1/1", block, m_axis_tvalid); else passes++;
    @(posedge clock);
    #3 reset_n = 1'b0;
    cfg_run = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) $display("FAIL arst_stream got v=%b l=%b d=%h want 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata); else passes++;
    checks++; if (ram_en !== 1'b0 || ram_addr !== '0) $display("FAIL arst_ram got en=%b addr=%h want 0/0", ram_en, ram_addr); else passes++;
    checks++; if (busy !== 1'b0 || block !== 1'b0 || pass_count !== 16'd0) $display("FAIL arst_status got busy=%b block=%b pass=%0d want 0", busy, block, pass_count); else passes++;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    exp_pass = 0;
    repeat (5) @(negedge clock);
    checks++; if (busy !== 1'b0 || ram_en !== 1'b0 || m_axis_tvalid !== 1'b0) $display("FAIL arst_stay_idle got busy=%b en=%b v=%b want 0", busy, ram_en, m_axis_tvalid); else passes++;
    cfg_stall_limit = 0; m_axis_tready = 1'b1;
    clear_mon();
    start_run(c0);
    repeat (7) @(posedge clock);
    stop_run();
    wait_idle();
    n = q_data.size();
    checks++; if (n != 8 || seq_errors(0, n, 4) != 0) $display("FAIL arst_rerun got %0d words %0d bad want 8/0", n, seq_errors(0, n, 4)); else passes++;
    exp_pass += 2;
    checks++; if (pass_count !== 16'(exp_pass)) $display("FAIL arst_pass got %0d want %0d", pass_count, exp_pass); else passes++;
  endtask

  initial begin
    test_reset();
    test_stream_len4();
    test_random_backpressure();
    test_drain();
    test_watchdog();
    test_length_edges();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
